// File: rtl/usb_link_pkg.sv
// Shared opcodes, frame headers and FSM state types for the USB link scheduler.
package usb_link_pkg;

   localparam logic [7:0] OP_WRITE_CTRL = 8'h01;
   localparam logic [7:0] OP_READ_CTRL  = 8'h02;
   localparam logic [7:0] OP_START      = 8'h03;
   localparam logic [7:0] OP_STOP       = 8'h04;

   localparam logic [7:0] HDR_ACK    = 8'hA5;
   localparam logic [7:0] HDR_ERR    = 8'hEE;
   localparam logic [7:0] HDR_SAMPLE = 8'h5A;

   typedef enum logic {
      R_OPCODE,
      R_ARG
   } rx_state_t;

   typedef enum logic [1:0] {
      T_IDLE,
      T_RESP,
      T_SAMPLE
   } tx_state_t;

endpackage

// File: rtl/usb_cmd_parser.sv
// RX command parser: turns opcode/argument byte pairs into control register
// writes and stream enables, and queues one 2-byte response for the TX side.
module usb_cmd_parser
   import usb_link_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0]  CTRL_RESET     = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_byte,
   input  logic       rx_valid,
   input  logic       slot_load,
   output logic [7:0] control,
   output logic       stream_en,
   output logic       resp_overrun,
   output logic       slot_full,
   output logic [7:0] slot_hdr,
   output logic [7:0] slot_payload
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   rx_state_t        state;
   rx_state_t        next_state;
   logic [7:0]       opcode;
   logic [CNT_W-1:0] cnt;
   logic             cmd_done;
   logic [7:0]       resp_hdr;
   logic [7:0]       resp_payload;

   // Parser state register
   always_ff @(posedge clk) begin
      if (!reset) state <= R_OPCODE;
      else        state <= next_state;
   end

   // Next-state decode, command completion strobe and response formatting
   always_comb begin
      next_state   = state;
      cmd_done     = 1'b0;
      resp_hdr     = HDR_ACK;
      resp_payload = 8'h00;
      case (state)
         R_OPCODE: if (rx_valid) next_state = R_ARG;
         R_ARG: begin
            if (rx_valid) begin
               next_state = R_OPCODE;
               cmd_done   = 1'b1;
            end else if (cnt == CNT_LAST) begin
               // Host went quiet after the opcode: drop the half command.
               next_state = R_OPCODE;
            end
         end
         default: next_state = R_OPCODE;
      endcase
      case (opcode)
         OP_WRITE_CTRL: resp_payload = rx_byte;
         OP_READ_CTRL:  resp_payload = control;
         OP_START:      resp_payload = OP_START;
         OP_STOP:       resp_payload = OP_STOP;
         default: begin
            resp_hdr     = HDR_ERR;
            resp_payload = opcode;
         end
      endcase
   end

   // Opcode latch, argument timeout, command execution and response slot
   always_ff @(posedge clk) begin
      if (!reset) begin
         opcode       <= 8'h00;
         cnt          <= '0;
         control      <= CTRL_RESET;
         stream_en    <= 1'b0;
         resp_overrun <= 1'b0;
         slot_full    <= 1'b0;
         slot_hdr     <= 8'h00;
         slot_payload <= 8'h00;
      end else begin
         if (state == R_OPCODE && rx_valid) begin
            opcode <= rx_byte;
            cnt    <= '0;
         end else if (state == R_ARG) begin
            cnt <= cnt + CNT_ONE;
         end

         // Commands always take effect, whether or not their response fits.
         if (cmd_done) begin
            case (opcode)
               OP_WRITE_CTRL: control   <= rx_byte;
               OP_START:      stream_en <= 1'b1;
               OP_STOP:       stream_en <= 1'b0;
               default: ;
            endcase
         end

         // A slot being unloaded this cycle counts as free for a new response.
         if (cmd_done && (!slot_full || slot_load)) begin
            slot_full    <= 1'b1;
            slot_hdr     <= resp_hdr;
            slot_payload <= resp_payload;
         end else begin
            if (slot_load) slot_full    <= 1'b0;
            if (cmd_done)  resp_overrun <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/usb_link_scheduler.sv
// Link scheduler top: command parser plus a TX arbiter that sends either a
// 2-byte response frame or a 5-byte sample frame, never interleaving frames.
module usb_link_scheduler
   import usb_link_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter logic [7:0]  CTRL_RESET     = 8'h00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [31:0] sample_data,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic [7:0]  control,
   output logic        stream_en,
   output logic        resp_overrun
);

   // Handshakes: a byte/word moves on a rising edge where valid && ready are
   // both high; the sender holds valid and data steady until that edge.

   tx_state_t   state;
   tx_state_t   next_state;
   logic        slot_load;
   logic        slot_full;
   logic [7:0]  slot_hdr;
   logic [7:0]  slot_payload;
   logic [39:0] frame;
   logic [2:0]  remain;

   usb_cmd_parser #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CTRL_RESET     (CTRL_RESET)
   ) u_parser (
      .clk          (clk),
      .reset        (reset),
      .rx_byte      (rx_byte),
      .rx_valid     (rx_valid),
      .slot_load    (slot_load),
      .control      (control),
      .stream_en    (stream_en),
      .resp_overrun (resp_overrun),
      .slot_full    (slot_full),
      .slot_hdr     (slot_hdr),
      .slot_payload (slot_payload)
   );

   // The outgoing byte is always the top of the frame shift register.
   assign tx_byte = frame[39:32];

   // TX state register
   always_ff @(posedge clk) begin
      if (!reset) state <= T_IDLE;
      else        state <= next_state;
   end

   // Arbitration in idle (responses win) and end-of-frame detection
   always_comb begin
      next_state   = state;
      slot_load    = 1'b0;
      sample_ready = 1'b0;
      tx_valid     = (state != T_IDLE);
      case (state)
         T_IDLE: begin
            sample_ready = stream_en && !slot_full;
            if (slot_full) begin
               slot_load  = 1'b1;
               next_state = T_RESP;
            end else if (sample_valid && sample_ready) begin
               next_state = T_SAMPLE;
            end
         end
         T_RESP, T_SAMPLE: begin
            if (tx_ready && remain == 3'd1) next_state = T_IDLE;
         end
         default: next_state = T_IDLE;
      endcase
   end

   // Frame load on arbitration, then shift one byte per accepted transfer
   always_ff @(posedge clk) begin
      if (!reset) begin
         frame  <= 40'h0;
         remain <= 3'd0;
      end else begin
         case (state)
            T_IDLE: begin
               if (slot_load) begin
                  frame  <= {slot_hdr, slot_payload, 24'h0};
                  remain <= 3'd2;
               end else if (next_state == T_SAMPLE) begin
                  frame  <= {HDR_SAMPLE, sample_data};
                  remain <= 3'd5;
               end
            end
            default: begin
               if (tx_ready) begin
                  frame  <= {frame[31:0], 8'h00};
                  remain <= remain - 3'd1;
               end
            end
         endcase
      end
   end

endmodule
